calc_engine: RTL and testbench

//  Parametrised keypad calculator datapath: hex digit entry into X, operand Y, operator,

---
 rtl/calc_engine.sv | 184 ++++++++++++++++++
 tb/tb_calc_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_engine.sv
// Keypad calculator datapath: hex entry into x, operand y, memory m, +,-,*,/ with sticky flags.
// MUL/DIV run WIDTH iterations on a shared shift/add / restoring-divide unit; keys are dropped while busy.
module calc_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_key,
  input  logic [4:0]       keycode,
  output logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] K_CE  = 5'b00000;
  localparam logic [4:0] K_MS  = 5'b00001;
  localparam logic [4:0] K_AC  = 5'b00010;
  localparam logic [4:0] K_MP  = 5'b00011;
  localparam logic [4:0] K_EQ  = 5'b00100;
  localparam logic [4:0] K_ADD = 5'b01000;
  localparam logic [4:0] K_SUB = 5'b01001;
  localparam logic [4:0] K_MUL = 5'b01010;
  localparam logic [4:0] K_DIV = 5'b01011;
  localparam logic [4:0] K_MR  = 5'b01100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIVZ} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t           state, next_state;
  op_t              op;
  logic [WIDTH-1:0] y, m;
  logic [WIDTH-1:0] hi, lo, dvs;
  logic [CW-1:0]    cnt;
  logic             key_act, iterate, finish;

  logic [WIDTH:0]   add_sum, sub_diff, mul_sum, div_tmp;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;

  assign key_act = new_key && !busy;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (key_act && keycode == K_EQ) begin
          if (op == OP_MUL)      next_state = S_MUL;
          else if (op == OP_DIV) next_state = (x == '0) ? S_DIVZ : S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt == CW'(WIDTH)) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    case (state)
      S_MUL, S_DIV: begin
        busy    = 1'b1;
        iterate = (cnt != CW'(WIDTH));
        finish  = (cnt == CW'(WIDTH));
      end
      S_DIVZ:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // hi:lo is the product accumulator for MUL and remainder:quotient for DIV
  always_comb begin
    add_sum  = {1'b0, y} + {1'b0, x};
    sub_diff = {1'b0, y} - {1'b0, x};
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    div_tmp  = {hi, lo[WIDTH-1]};
    div_ge   = (div_tmp >= {1'b0, dvs});
    div_sub  = div_tmp[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x   <= '0;
      y   <= '0;
      m   <= '0;
      op  <= OP_NONE;
      ovf <= 1'b0;
      err <= 1'b0;
      hi  <= '0;
      lo  <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (busy) begin
      if (iterate) begin
        cnt <= cnt + CW'(1);
        if (state == S_MUL) begin
          {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
        end else begin
          hi <= div_ge ? div_sub : div_tmp[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], div_ge};
        end
      end
      if (finish) begin
        x  <= lo;
        y  <= '0;
        op <= OP_NONE;
        if (state == S_MUL && hi != '0) ovf <= 1'b1;
      end
      if (state == S_DIVZ) begin
        x   <= '1;
        y   <= '0;
        op  <= OP_NONE;
        err <= 1'b1;
      end
    end else if (new_key) begin
      if (keycode[4]) begin
        x <= {x[WIDTH-5:0], keycode[3:0]};
      end else begin
        case (keycode)
          K_CE: x <= '0;
          K_MS: m <= x;
          K_MP: m <= m + x;
          K_MR: x <= m;
          K_AC: begin
            x   <= '0;
            y   <= '0;
            op  <= OP_NONE;
            ovf <= 1'b0;
            err <= 1'b0;
          end
          K_ADD, K_SUB, K_MUL, K_DIV: begin
            y <= x;
            x <= '0;
            case (keycode)
              K_ADD:   op <= OP_ADD;
              K_SUB:   op <= OP_SUB;
              K_MUL:   op <= OP_MUL;
              default: op <= OP_DIV;
            endcase
          end
          K_EQ: begin
            case (op)
              OP_ADD: begin
                x  <= add_sum[WIDTH-1:0];
                y  <= '0;
                op <= OP_NONE;
                if (add_sum[WIDTH]) ovf <= 1'b1;
              end
              OP_SUB: begin
                x  <= sub_diff[WIDTH-1:0];
                y  <= '0;
                op <= OP_NONE;
                if (sub_diff[WIDTH]) ovf <= 1'b1;
              end
              OP_MUL: begin
                hi  <= '0;
                lo  <= x;
                dvs <= y;
                cnt <= '0;
              end
              OP_DIV: begin
                hi  <= '0;
                lo  <= y;
                dvs <= x;
                cnt <= '0;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine at WIDTH=16 and WIDTH=32; sel chooses which instance receives keys.
module tb_calc_engine;

  localparam logic [4:0] K_DIG = 5'b10000;
  localparam logic [4:0] K_CE  = 5'b00000;
  localparam logic [4:0] K_MS  = 5'b00001;
  localparam logic [4:0] K_AC  = 5'b00010;
  localparam logic [4:0] K_MP  = 5'b00011;
  localparam logic [4:0] K_EQ  = 5'b00100;
  localparam logic [4:0] K_ADD = 5'b01000;
  localparam logic [4:0] K_SUB = 5'b01001;
  localparam logic [4:0] K_MUL = 5'b01010;
  localparam logic [4:0] K_DIV = 5'b01011;
  localparam logic [4:0] K_MR  = 5'b01100;

  logic        clock = 1'b0;
  logic        reset;
  logic        new_key;
  logic [4:0]  keycode;
  logic        sel;
  logic        nk16, nk32;
  logic [15:0] x16;
  logic [31:0] x32;
  logic        b16, o16, e16, b32, o32, e32;
  logic [31:0] cx;
  logic        cb, co, ce;
  int          checks = 0;
  int          failures = 0;

  assign nk16 = new_key & ~sel;
  assign nk32 = new_key & sel;
  assign cx   = sel ? x32 : {16'h0, x16};
  assign cb   = sel ? b32 : b16;
  assign co   = sel ? o32 : o16;
  assign ce   = sel ? e32 : e16;

  calc_engine #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .new_key(nk16), .keycode(keycode),
    .x(x16), .busy(b16), .ovf(o16), .err(e16)
  );

  calc_engine #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .new_key(nk32), .keycode(keycode),
    .x(x32), .busy(b32), .ovf(o32), .err(e32)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [4:0] c);
    @(negedge clock);
    keycode = c;
    new_key = 1'b1;
    @(negedge clock);
    new_key = 1'b0;
  endtask

  task automatic enter(input logic [31:0] v);
    int n;
    n = sel ? 8 : 4;
    for (int i = n - 1; i >= 0; i--) press({1'b1, v[4*i +: 4]});
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic long32(input logic [31:0] a, input logic [31:0] b, input logic div);
    logic [63:0] p;
    logic [31:0] expx;
    logic        expo;
    p    = {32'h0, a} * {32'h0, b};
    expx = div ? a / b : p[31:0];
    expo = div ? 1'b0 : (p[63:32] != 32'h0);
    press(K_AC);
    enter(a);
    press(div ? K_DIV : K_MUL);
    enter(b);
    press(K_EQ);
    tick(32);
    check("w32_busy_hold", {63'h0, cb}, 64'h1);
    check("w32_x_hold", {32'h0, cx}, {32'h0, b});
    tick(1);
    check("w32_result", {32'h0, cx}, {32'h0, expx});
    check("w32_busy_done", {63'h0, cb}, 64'h0);
    check("w32_ovf", {63'h0, co}, {63'h0, expo});
  endtask

  initial begin
    reset   = 1'b1;
    new_key = 1'b0;
    keycode = 5'h0;
    sel     = 1'b0;
    tick(2);
    check("rst_x", {32'h0, cx}, 64'h0);
    check("rst_busy", {63'h0, cb}, 64'h0);
    check("rst_ovf", {63'h0, co}, 64'h0);
    check("rst_err", {63'h0, ce}, 64'h0);
    reset = 1'b0;

    press(K_DIG | 5'h1); press(K_DIG | 5'h2); press(K_DIG | 5'h3); press(K_DIG | 5'h4);
    check("digits4", {32'h0, cx}, 64'h1234);
    press(K_DIG | 5'h5);
    check("digit_shift_out", {32'h0, cx}, 64'h2345);

    press(K_AC);
    enter(32'h0012);
    press(K_ADD);
    check("op_clears_x", {32'h0, cx}, 64'h0);
    enter(32'h0034);
    press(K_EQ);
    check("add", {32'h0, cx}, 64'h0046);
    check("add_ovf", {63'h0, co}, 64'h0);

    press(K_AC);
    enter(32'h0003);
    press(K_SUB);
    enter(32'h0005);
    press(K_EQ);
    check("sub_borrow_x", {32'h0, cx}, 64'hFFFE);
    check("sub_borrow_ovf", {63'h0, co}, 64'h1);
    press(K_AC);
    check("ac_ovf", {63'h0, co}, 64'h0);
    check("ac_x", {32'h0, cx}, 64'h0);

    enter(32'h0100);
    press(K_MUL);
    enter(32'h0100);
    press(K_EQ);
    check("mul_busy_rise", {63'h0, cb}, 64'h1);
    press(K_DIG | 5'h9);
    tick(14);
    check("mul_busy_hold", {63'h0, cb}, 64'h1);
    check("mul_x_hold", {32'h0, cx}, 64'h0100);
    tick(1);
    check("mul_result", {32'h0, cx}, 64'h0000);
    check("mul_busy_fall", {63'h0, cb}, 64'h0);
    check("mul_ovf", {63'h0, co}, 64'h1);

    press(K_AC);
    enter(32'h00FF);
    press(K_DIV);
    enter(32'h0010);
    press(K_EQ);
    tick(16);
    check("div_busy_hold", {63'h0, cb}, 64'h1);
    check("div_x_hold", {32'h0, cx}, 64'h0010);
    keycode = K_DIG | 5'h9;
    new_key = 1'b1;
    tick(1);
    new_key = 1'b0;
    check("div_result", {32'h0, cx}, 64'h000F);
    check("div_busy_fall", {63'h0, cb}, 64'h0);
    tick(1);
    check("div_fall_key_dropped", {32'h0, cx}, 64'h000F);

    press(K_AC);
    enter(32'h0005);
    press(K_DIV);
    press(K_EQ);
    check("dz_busy", {63'h0, cb}, 64'h1);
    tick(1);
    check("dz_x", {32'h0, cx}, 64'hFFFF);
    check("dz_err", {63'h0, ce}, 64'h1);
    check("dz_busy_fall", {63'h0, cb}, 64'h0);
    press(K_AC);
    check("dz_ac_x", {32'h0, cx}, 64'h0);
    check("dz_ac_err", {63'h0, ce}, 64'h0);

    press(K_DIG | 5'h7);
    press(K_MS);
    press(K_MP);
    check("mem_x_kept", {32'h0, cx}, 64'h0007);
    press(K_CE);
    check("ce", {32'h0, cx}, 64'h0);
    press(K_MR);
    check("mem_recall", {32'h0, cx}, 64'h000E);

    press(K_AC);
    enter(32'h0100);
    press(K_MUL);
    enter(32'h0100);
    press(K_EQ);
    tick(5);
    reset = 1'b1;
    tick(1);
    check("rst_mid_x", {32'h0, cx}, 64'h0);
    check("rst_mid_busy", {63'h0, cb}, 64'h0);
    check("rst_mid_ovf", {63'h0, co}, 64'h0);
    check("rst_mid_err", {63'h0, ce}, 64'h0);
    reset = 1'b0;
    press(K_MR);
    check("rst_clears_m", {32'h0, cx}, 64'h0);

    sel = 1'b1;
    long32(32'h00012345, 32'h00006789, 1'b0);
    long32(32'h00100000, 32'h00001000, 1'b0);
    long32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    long32(32'hDEADBEEF, 32'h00001234, 1'b1);
    long32(32'h00000007, 32'hFFFFFFFF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
